// File: rtl/fp_sqrt_iter_if.sv
// Request/response bundle for fp_sqrt_iter. The rem signal exists only when
// FP_SQRT_ITER_REM_EN is defined.
interface fp_sqrt_iter_if #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16
);
  localparam int ITERS = (WIDTH + FRAC_WIDTH + 1) / 2;

  logic             go;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

`ifdef FP_SQRT_ITER_REM_EN
  logic [ITERS:0]   rem;

  modport master (output go, output in, input out, input done, input busy, input rem);
  modport slave  (input go, input in, output out, output done, output busy, output rem);
`else
  modport master (output go, output in, input out, input done, input busy);
  modport slave  (input go, input in, output out, output done, output busy);
`endif
endinterface

// File: rtl/fp_sqrt_iter.sv
// Unsigned fixed-point square root, restoring radix-2 digit recurrence, DIGITS_PER_CYCLE bits per cycle.
// Define FP_SQRT_ITER_REM_EN to expose the final remainder (radicand - root^2) on bus.rem.
module fp_sqrt_iter #(
  parameter int WIDTH            = 32,
  parameter int INT_WIDTH        = 16,
  parameter int FRAC_WIDTH       = 16,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  fp_sqrt_iter_if.slave bus
);
  localparam int R       = ((WIDTH + FRAC_WIDTH + 1) / 2) * 2;
  localparam int ITERS   = R / 2;
  localparam int D_SAFE  = (DIGITS_PER_CYCLE < 1) ? 1 : DIGITS_PER_CYCLE;
  localparam int N       = (ITERS + D_SAFE - 1) / D_SAFE;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((INT_WIDTH + FRAC_WIDTH != WIDTH) || (DIGITS_PER_CYCLE < 1) ||
      (DIGITS_PER_CYCLE > ITERS)) begin : g_param_check
    $error("fp_sqrt_iter: illegal parameters WIDTH=%0d INT_WIDTH=%0d FRAC_WIDTH=%0d DIGITS_PER_CYCLE=%0d",
           WIDTH, INT_WIDTH, FRAC_WIDTH, DIGITS_PER_CYCLE);
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [R-1:0]       rad_reg, rad_w, rad_load;
  logic [ITERS+1:0]   rem_reg, rem_w, rem_try, trial;
  logic [ITERS-1:0]   root_reg, root_w;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               accept;
  logic               last_cycle;

  // Radicand is the operand scaled by 2^FRAC_WIDTH, zero-extended to R bits.
  assign rad_load = R'(bus.in) << FRAC_WIDTH;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_cycle = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.go) begin
          accept     = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_reg == CNT_LAST) begin
          last_cycle = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.go) begin
          accept     = 1'b1;
          state_next = S_BUSY;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Chained restoring steps; steps beyond ITERS on the final cycle pass through untouched.
  always_comb begin
    rad_w   = rad_reg;
    rem_w   = rem_reg;
    root_w  = root_reg;
    rem_try = '0;
    trial   = '0;
    for (int i = 0; i < D_SAFE; i++) begin
      if (int'(cnt_reg) * D_SAFE + i < ITERS) begin
        rem_try = {rem_w[ITERS-1:0], rad_w[R-1 -: 2]};
        trial   = {root_w, 2'b01};
        root_w  = root_w << 1;
        if (rem_try >= trial) begin
          rem_w     = rem_try - trial;
          root_w[0] = 1'b1;
        end else begin
          rem_w = rem_try;
        end
        rad_w = rad_w << 2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      rad_reg   <= '0;
      rem_reg   <= '0;
      root_reg  <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rad_reg  <= rad_load;
        rem_reg  <= '0;
        root_reg <= '0;
        cnt_reg  <= '0;
      end else if (state_reg == S_BUSY) begin
        rad_reg  <= rad_w;
        rem_reg  <= rem_w;
        root_reg <= root_w;
        cnt_reg  <= cnt_reg + 1'b1;
      end
      if (last_cycle) begin
        out_reg <= WIDTH'(root_w);
      end
    end
  end

`ifdef FP_SQRT_ITER_REM_EN
  logic [ITERS:0] rem_out_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_out_reg <= '0;
    end else if (last_cycle) begin
      rem_out_reg <= rem_w[ITERS:0];
    end
  end

  assign bus.rem = rem_out_reg;
`endif

  assign bus.out  = out_reg;
  assign bus.done = (state_reg == S_DONE);
  assign bus.busy = (state_reg == S_BUSY);
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: integer D=1, fixed-point D=4 and D=5 (partial last cycle).
// Rem checks are active when FP_SQRT_ITER_REM_EN is defined.
module tb_fp_sqrt_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] o;
    logic [32:0] r;
    int unsigned acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int          busy_run [3];
  logic [31:0] last_out [3];

  fp_sqrt_iter_if #(.WIDTH(32), .FRAC_WIDTH(0))  b0 ();
  fp_sqrt_iter_if #(.WIDTH(32), .FRAC_WIDTH(16)) b1 ();
  fp_sqrt_iter_if #(.WIDTH(32), .FRAC_WIDTH(16)) b2 ();

  fp_sqrt_iter #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .DIGITS_PER_CYCLE(1))
    u0 (.clk(clk), .reset(rst_n), .bus(b0));
  fp_sqrt_iter #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .DIGITS_PER_CYCLE(4))
    u1 (.clk(clk), .reset(rst_n), .bus(b1));
  fp_sqrt_iter #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .DIGITS_PER_CYCLE(5))
    u2 (.clk(clk), .reset(rst_n), .bus(b2));

  logic [32:0] rem0, rem1, rem2;
`ifdef FP_SQRT_ITER_REM_EN
  assign rem0 = 33'(b0.rem);
  assign rem1 = 33'(b1.rem);
  assign rem2 = 33'(b2.rem);
`else
  assign rem0 = '0;
  assign rem1 = '0;
  assign rem2 = '0;
`endif

  // Cycles in BUSY per instance: ITERS=16/D=1, ITERS=24/D=4, ITERS=24/D=5.
  function automatic int n_of(input int id);
    case (id)
      0:       return 16;
      1:       return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [63:0] lo, hi, mid;
    lo = 64'd0;
    hi = 64'd1 << 25;
    while (lo < hi) begin
      mid = (lo + hi + 64'd1) >> 1;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 64'd1;
    end
    return lo[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon(input int id, input logic dn, input logic bz,
                     input logic [31:0] o, input logic [32:0] r);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!rst_n) begin
      busy_run[id] = 0;
      last_out[id] = '0;
      return;
    end
    if (dn) begin
      case (id)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        chk($sformatf("spurious_done%0d", id), 64'd1, 64'd0);
      end else begin
        chk($sformatf("out%0d", id), 64'(o), 64'(e.o));
        chk($sformatf("latency%0d", id), 64'(cyc - e.acc), 64'(n_of(id)));
        chk($sformatf("busy_len%0d", id), 64'(busy_run[id]), 64'(n_of(id)));
`ifdef FP_SQRT_ITER_REM_EN
        chk($sformatf("rem%0d", id), 64'(r), 64'(e.r));
`endif
        last_out[id] = e.o;
      end
      busy_run[id] = 0;
    end
    if (bz) begin
      busy_run[id]++;
      chk($sformatf("out_hold%0d", id), 64'(o), 64'(last_out[id]));
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.done, b0.busy, b0.out, rem0);
    mon(1, b1.done, b1.busy, b1.out, rem1);
    mon(2, b2.done, b2.busy, b2.out, rem2);
  end

  task automatic wait_done(input int id);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((id == 0 && b0.done) || (id == 1 && b1.done) || (id == 2 && b2.done)) return;
    end
    chk($sformatf("timeout%0d", id), 64'd0, 64'd1);
  endtask

  task automatic issue0(input logic [31:0] v, input logic [31:0] r);
    exp_t e;
    e.o   = r;
    e.r   = 33'(64'(v) - 64'(r) * 64'(r));
    e.acc = cyc + 1;
    q0.push_back(e);
    b0.go = 1'b1;
    b0.in = v;
    @(negedge clk);
    b0.go = 1'b0;
    b0.in = $urandom;
    wait_done(0);
    @(negedge clk);
  endtask

  task automatic issue12(input logic [31:0] v, input logic [31:0] r);
    exp_t e;
    e.o   = r;
    e.r   = 33'((64'(v) << 16) - 64'(r) * 64'(r));
    e.acc = cyc + 1;
    q1.push_back(e);
    q2.push_back(e);
    b1.go = 1'b1;
    b2.go = 1'b1;
    b1.in = v;
    b2.in = v;
    @(negedge clk);
    b1.go = 1'b0;
    b2.go = 1'b0;
    b1.in = $urandom;
    b2.in = $urandom;
    wait_done(1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    exp_t        e;
    bit          seen;
    rst_n = 1'b0;
    b0.go = 1'b0; b1.go = 1'b0; b2.go = 1'b0;
    b0.in = '0;   b1.in = '0;   b2.in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out0", 64'(b0.out), 64'd0);
    chk("rst_done0", 64'(b0.done), 64'd0);
    chk("rst_busy0", 64'(b0.busy), 64'd0);
    chk("rst_out1", 64'(b1.out), 64'd0);
`ifdef FP_SQRT_ITER_REM_EN
    chk("rst_rem0", 64'(rem0), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Integer square roots, including both extremes.
    issue0(32'd16, 32'd4);
    issue0(32'hFFFF_FFFF, 32'd65535);
    issue0(32'd0, 32'd0);
    issue0(32'd17, 32'd4);

    // Q16.16: sqrt(2.0), sqrt(4.0), all-ones, smallest nonzero, zero.
    issue12(32'h0002_0000, 32'h0001_6A09);
    issue12(32'h0004_0000, 32'h0002_0000);
    issue12(32'hFFFF_FFFF, 32'h00FF_FFFF);
    issue12(32'h0000_0001, 32'h0000_0100);
    issue12(32'h0000_0000, 32'h0000_0000);

    // go held through BUSY with in toggling, then back-to-back accept in the DONE cycle.
    e.o = 32'd7; e.r = 33'd0; e.acc = cyc + 1;
    q0.push_back(e);
    b0.go = 1'b1;
    b0.in = 32'd49;
    seen  = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (b0.done) seen = 1'b1;
      else b0.in = $urandom;
    end
    if (!seen) chk("timeout_held", 64'd0, 64'd1);
    e.o = 32'd3; e.r = 33'd0; e.acc = cyc + 1;
    q0.push_back(e);
    b0.in = 32'd9;
    @(negedge clk);
    b0.go = 1'b0;
    b0.in = $urandom;
    wait_done(0);
    @(negedge clk);

    // Reset in the middle of a computation: no done may follow.
    b0.go = 1'b1;
    b0.in = 32'd200;
    @(negedge clk);
    b0.go = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out0", 64'(b0.out), 64'd0);
    chk("midrst_done0", 64'(b0.done), 64'd0);
    chk("midrst_busy0", 64'(b0.busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    issue0(32'd100, 32'd10);

    // Random sweep against an independent binary-search isqrt.
    for (int k = 0; k < 6; k++) begin
      v = $urandom;
      issue0(v, isqrt(64'(v)));
    end
    for (int k = 0; k < 6; k++) begin
      v = $urandom;
      issue12(v, isqrt(64'(v) << 16));
    end

    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
